multilane_frame_checker: RTL and testbench
==========================================

Name: multilane_frame_checker

Overview:
- Checks the counting test pattern on N_LANES independent raw 64b/8c receive lanes. In each lane the frame generator sends every data block with all bytes equal to a per-block counter that increments modulo 2^NB_BYTE.
- Sits after the decoder/reorder stage in the test datapath.
- Adds over the single-lane checker: hysteresis on lock acquire and loss, a saturating error counter per lane, a synchronous counter clear, and per-lane state and all-lanes lock status.

Parameters:
- N_LANES, 4, number of independent lanes checked.
- NB_DATA_RAW, 64, data width per lane.
- NB_CTRL_RAW, 8, control width per lane.
- NB_BYTE, 8, pattern symbol width; the expected counter is NB_BYTE bits wide.
- NB_ERROR_COUNTER, 16, width of each lane's error counter.
- LOCK_THRESHOLD, 4, consecutive matching blocks needed to lock, seed block included. Must be >= 2.
- UNLOCK_THRESHOLD, 3, consecutive mismatches while locked before lock is lost. Must be >= 1.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  clock enable shared by all lanes; low freezes all state and counters.
- i_clear_counters  in  1  synchronous clear of all error counters; does not depend on i_enable.
- i_rx_raw_data  in  N_LANES*NB_DATA_RAW  lane k occupies bits [k*NB_DATA_RAW +: NB_DATA_RAW].
- i_rx_raw_ctrl  in  N_LANES*NB_CTRL_RAW  lane k occupies bits [k*NB_CTRL_RAW +: NB_CTRL_RAW].
- o_error_counter  out  N_LANES*NB_ERROR_COUNTER  per-lane saturating error count, same packing as the inputs.
- o_lock  out  N_LANES  per lane, 1 when the lane is in LOCK or SLIP.
- o_all_lock  out  1  AND of all o_lock bits.
- o_lane_state  out  2*N_LANES  per-lane state code: LOSS=0, ACQ=1, LOCK=2, SLIP=3.

Behaviour:
- Per-lane definitions:
  - Byte 0 is the MS byte of the lane word.
  - Block is consistent when all NB_DATA_RAW/NB_BYTE bytes are equal.
  - Block matches when it is consistent and byte0 == expected.
  - Block is valid when i_enable=1 and the lane's ctrl bits are all 0.
- Invalid blocks (ctrl or disabled) do not change that lane's state, expected value, run counters or error counter.
- Registers per lane:
  - state (2b)
  - expected (NB_BYTE)
  - good_cnt (sized for LOCK_THRESHOLD)
  - bad_cnt (sized for UNLOCK_THRESHOLD)
  - err_cnt (NB_ERROR_COUNTER)
- Expected arithmetic: on every valid block in ACQ, LOCK and SLIP, expected <= expected+1 mod 2^NB_BYTE (0xFF wraps to 0x00), whether or not the block matched.
- State machine, evaluated on valid blocks only:
  - LOSS:
    - Consistent block -> ACQ; expected <= byte0+1; good_cnt <= 1.
    - Otherwise stay in LOSS.
  - ACQ:
    - Match -> good_cnt+1. When good_cnt+1 == LOCK_THRESHOLD -> LOCK, bad_cnt <= 0.
    - Mismatch but consistent -> stay in ACQ and reseed: expected <= byte0+1, good_cnt <= 1.
    - Inconsistent -> LOSS.
  - LOCK:
    - Match -> stay in LOCK.
    - Mismatch -> err_cnt +1; bad_cnt <= 1; go to SLIP. If UNLOCK_THRESHOLD == 1, go to LOSS instead.
  - SLIP:
    - Match -> LOCK; bad_cnt <= 0.
    - Mismatch -> err_cnt +1; bad_cnt+1. When that reaches UNLOCK_THRESHOLD -> LOSS.
- Errors are counted only in LOCK and SLIP. Mismatches in LOSS and ACQ are never counted.
- err_cnt saturates at all-ones and never wraps.
- If i_clear_counters and an increment occur in the same cycle, the clear wins (result 0).
- Latency: all outputs come straight from registers. o_lock / o_lane_state reflect a block's effect one clock after that block is sampled.
- Reset (async, any time including mid-acquisition):
  - state = LOSS, expected = 0, good_cnt = 0, bad_cnt = 0, err_cnt = 0.
  - o_lock = 0, o_all_lock = 0, o_lane_state = 0.
- Lanes are fully independent: no shared state apart from i_enable, i_clear_counters and o_all_lock.

Test Plan:
- Lane 0 sends blocks 0x10..10, 0x11..11, 0x12..12, 0x13..13 (ctrl=0) -> o_lane_state[1:0]: ACQ after the 1st block, LOCK after the 4th, o_lock[0]=1; error counter stays 0.
- Locked lane receives 0xFE.., 0xFF.., 0x00.., 0x01.. -> stays in LOCK across the wrap; 0 errors.
- Locked lane with a ctrl block (ctrl=0x80) inserted between 0x20 and 0x21 -> ctrl block ignored, lock held; then one corrupted block 0x22..22 replaced by 0xAA..AA -> SLIP, error=1; next 0x23 -> LOCK. Then 3 consecutive bad blocks -> LOSS, error=4.
- Error counter preloaded near max (NB_ERROR_COUNTER=4, 20 mismatches while alternating LOCK/SLIP) -> saturates at 15. Assert i_clear_counters together with a mismatch -> reads 0.
- All 4 lanes locked on different seeds (0x00, 0x40, 0x80, 0xC0) -> o_all_lock=1. Break lane 2 only -> o_all_lock=0, lanes 0, 1 and 3 unaffected.
- Assert i_reset asynchronously mid-ACQ (good_cnt=2) and mid-SLIP -> outputs zero immediately, without a clock edge; a fresh 4-block sequence is then needed to relock.

Source files
------------

// File: rtl/multilane_frame_checker_if.sv
// Bus bundle for multilane_frame_checker: per-lane raw receive words in, lock/error status out.
// A lane block is taken when i_enable is high and that lane's ctrl bits are all zero; there is no backpressure.
interface multilane_frame_checker_if #(
  parameter int N_LANES          = 4,
  parameter int NB_DATA_RAW      = 64,
  parameter int NB_CTRL_RAW      = 8,
  parameter int NB_ERROR_COUNTER = 16
);
  logic                                  i_enable;
  logic                                  i_clear_counters;
  logic [N_LANES*NB_DATA_RAW-1:0]        i_rx_raw_data;
  logic [N_LANES*NB_CTRL_RAW-1:0]        i_rx_raw_ctrl;
  logic [N_LANES*NB_ERROR_COUNTER-1:0]   o_error_counter;
  logic [N_LANES-1:0]                    o_lock;
  logic                                  o_all_lock;
  logic [2*N_LANES-1:0]                  o_lane_state;

  modport master (
    output i_enable, i_clear_counters, i_rx_raw_data, i_rx_raw_ctrl,
    input  o_error_counter, o_lock, o_all_lock, o_lane_state
  );

  modport slave (
    input  i_enable, i_clear_counters, i_rx_raw_data, i_rx_raw_ctrl,
    output o_error_counter, o_lock, o_all_lock, o_lane_state
  );
endinterface

// File: rtl/multilane_frame_checker.sv
// Counting-pattern checker for N_LANES independent raw lanes, with lock hysteresis and
// saturating per-lane error counters. Lane state is exported on o_lane_state.
module multilane_frame_checker #(
  parameter int N_LANES          = 4,
  parameter int NB_DATA_RAW      = 64,
  parameter int NB_CTRL_RAW      = 8,
  parameter int NB_BYTE          = 8,
  parameter int NB_ERROR_COUNTER = 16,
  parameter int LOCK_THRESHOLD   = 4,
  parameter int UNLOCK_THRESHOLD = 3
) (
  input logic                      i_clock,
  input logic                      i_reset,
  multilane_frame_checker_if.slave bus
);

  localparam int N_BYTES = NB_DATA_RAW / NB_BYTE;
  localparam int GW      = $clog2(LOCK_THRESHOLD + 1);
  localparam int BW      = $clog2(UNLOCK_THRESHOLD + 1);

  localparam logic [1:0] ST_LOSS = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;
  localparam logic [1:0] ST_SLIP = 2'd3;

  localparam logic [GW-1:0]               GOOD_LOCK = GW'(LOCK_THRESHOLD);
  localparam logic [BW-1:0]               BAD_LOSS  = BW'(UNLOCK_THRESHOLD);
  localparam logic [NB_ERROR_COUNTER-1:0] ERR_MAX   = '1;

  logic [1:0]                  state_q    [N_LANES];
  logic [NB_BYTE-1:0]          expected_q [N_LANES];
  logic [GW-1:0]               good_q     [N_LANES];
  logic [BW-1:0]               bad_q      [N_LANES];
  logic [NB_ERROR_COUNTER-1:0] err_q      [N_LANES];

  logic [NB_BYTE-1:0] byte0      [N_LANES];
  logic               consistent [N_LANES];
  logic               valid      [N_LANES];
  logic               match      [N_LANES];
  logic               err_inc    [N_LANES];

  // Byte 0 is the most significant byte of each lane word.
  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      byte0[k]      = bus.i_rx_raw_data[k*NB_DATA_RAW + NB_DATA_RAW - NB_BYTE +: NB_BYTE];
      consistent[k] = 1'b1;
      for (int b = 0; b < N_BYTES; b++) begin
        if (bus.i_rx_raw_data[k*NB_DATA_RAW + b*NB_BYTE +: NB_BYTE] != byte0[k]) begin
          consistent[k] = 1'b0;
        end
      end
      valid[k]   = bus.i_enable && (bus.i_rx_raw_ctrl[k*NB_CTRL_RAW +: NB_CTRL_RAW] == '0);
      match[k]   = consistent[k] && (byte0[k] == expected_q[k]);
      err_inc[k] = valid[k] && state_q[k][1] && !match[k];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_LANES; k++) begin
        state_q[k]    <= ST_LOSS;
        expected_q[k] <= '0;
        good_q[k]     <= '0;
        bad_q[k]      <= '0;
        err_q[k]      <= '0;
      end
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        if (valid[k]) begin
          case (state_q[k])
            ST_LOSS: begin
              if (consistent[k]) begin
                state_q[k]    <= ST_ACQ;
                expected_q[k] <= byte0[k] + 1'b1;
                good_q[k]     <= GW'(1);
              end
            end
            ST_ACQ: begin
              if (match[k]) begin
                expected_q[k] <= expected_q[k] + 1'b1;
                good_q[k]     <= good_q[k] + 1'b1;
                if (good_q[k] + 1'b1 == GOOD_LOCK) begin
                  state_q[k] <= ST_LOCK;
                  bad_q[k]   <= '0;
                end
              end else if (consistent[k]) begin
                // Reseed on a clean block that carries the wrong count.
                expected_q[k] <= byte0[k] + 1'b1;
                good_q[k]     <= GW'(1);
              end else begin
                expected_q[k] <= expected_q[k] + 1'b1;
                state_q[k]    <= ST_LOSS;
              end
            end
            ST_LOCK: begin
              expected_q[k] <= expected_q[k] + 1'b1;
              if (!match[k]) begin
                bad_q[k]   <= BW'(1);
                state_q[k] <= (UNLOCK_THRESHOLD == 1) ? ST_LOSS : ST_SLIP;
              end
            end
            default: begin
              expected_q[k] <= expected_q[k] + 1'b1;
              if (match[k]) begin
                state_q[k] <= ST_LOCK;
                bad_q[k]   <= '0;
              end else begin
                bad_q[k] <= bad_q[k] + 1'b1;
                if (bad_q[k] + 1'b1 == BAD_LOSS) begin
                  state_q[k] <= ST_LOSS;
                end
              end
            end
          endcase
        end

        // Clear has priority over a same-cycle increment and ignores i_enable.
        if (bus.i_clear_counters) begin
          err_q[k] <= '0;
        end else if (err_inc[k] && (err_q[k] != ERR_MAX)) begin
          err_q[k] <= err_q[k] + 1'b1;
        end
      end
    end
  end

  logic [N_LANES-1:0] lock_vec;

  always_comb begin
    lock_vec             = '0;
    bus.o_lane_state     = '0;
    bus.o_error_counter  = '0;
    for (int k = 0; k < N_LANES; k++) begin
      lock_vec[k]                                          = state_q[k][1];
      bus.o_lane_state[2*k +: 2]                           = state_q[k];
      bus.o_error_counter[k*NB_ERROR_COUNTER +: NB_ERROR_COUNTER] = err_q[k];
    end
    bus.o_lock     = lock_vec;
    bus.o_all_lock = &lock_vec;
  end

endmodule

// File: tb/tb_multilane_frame_checker.sv
// Self-checking bench for multilane_frame_checker: directed scenarios followed by random traffic,
// every cycle compared against a per-lane reference model of the pattern-lock rules.
module tb_multilane_frame_checker;

  localparam int N      = 4;
  localparam int NBE    = 4;
  localparam int LTH    = 4;
  localparam int UTH    = 3;
  localparam int ERRMAX = (1 << NBE) - 1;
  localparam int S_LOSS = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;
  localparam int S_SLIP = 3;
  localparam int W      = 2*N + N + 1 + N*NBE;

  logic i_clock;
  logic i_reset;

  multilane_frame_checker_if #(.N_LANES(N), .NB_DATA_RAW(64), .NB_CTRL_RAW(8),
                               .NB_ERROR_COUNTER(NBE)) bus ();

  multilane_frame_checker #(
    .N_LANES(N), .NB_DATA_RAW(64), .NB_CTRL_RAW(8), .NB_BYTE(8),
    .NB_ERROR_COUNTER(NBE), .LOCK_THRESHOLD(LTH), .UNLOCK_THRESHOLD(UTH)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus state ----------------
  logic [63:0] lane_data [N];
  logic [7:0]  lane_ctrl [N];
  int          seeds     [N];
  int          tx        [N];

  // ---------------- reference model ----------------
  int m_state [N];
  int m_exp   [N];
  int m_good  [N];
  int m_bad   [N];
  int m_err   [N];

  logic [W-1:0] exp_q [$];
  int n_checks;
  int n_fail;

  function automatic logic [63:0] pat(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_state[k] = S_LOSS; m_exp[k] = 0; m_good[k] = 0; m_bad[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit clr);
    for (int k = 0; k < N; k++) begin
      logic [63:0] w;
      int b0;
      bit cons, valid, hit, counted;
      w = lane_data[k];
      b0 = int'(w[63:56]);
      cons = 1'b1;
      for (int i = 0; i < 8; i++) if (int'(w[63-8*i -: 8]) != b0) cons = 1'b0;
      valid = en && (lane_ctrl[k] == 8'h00);
      hit = cons && (b0 == m_exp[k]);
      counted = 1'b0;
      if (valid) begin
        if (m_state[k] == S_LOSS) begin
          if (cons) begin m_state[k] = S_ACQ; m_exp[k] = (b0 + 1) % 256; m_good[k] = 1; end
        end else if (m_state[k] == S_ACQ) begin
          if (hit) begin
            m_good[k]++;
            m_exp[k] = (m_exp[k] + 1) % 256;
            if (m_good[k] == LTH) begin m_state[k] = S_LOCK; m_bad[k] = 0; end
          end else if (cons) begin
            m_exp[k] = (b0 + 1) % 256; m_good[k] = 1;
          end else begin
            m_exp[k] = (m_exp[k] + 1) % 256; m_state[k] = S_LOSS;
          end
        end else begin
          m_exp[k] = (m_exp[k] + 1) % 256;
          if (hit) begin
            m_state[k] = S_LOCK; m_bad[k] = 0;
          end else begin
            counted = 1'b1;
            m_bad[k] = (m_state[k] == S_LOCK) ? 1 : m_bad[k] + 1;
            m_state[k] = (m_bad[k] >= UTH) ? S_LOSS : S_SLIP;
          end
        end
      end
      if (clr) m_err[k] = 0;
      else if (counted && m_err[k] < ERRMAX) m_err[k]++;
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [2*N-1:0]   es;
    logic [N-1:0]     el;
    logic [N*NBE-1:0] ee;
    for (int k = 0; k < N; k++) begin
      es[2*k +: 2]   = 2'(m_state[k]);
      el[k]          = (m_state[k] == S_LOCK) || (m_state[k] == S_SLIP);
      ee[NBE*k +: NBE] = NBE'(m_err[k]);
    end
    return {es, el, &el, ee};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk({tag, "_state"},    32'(bus.o_lane_state),    32'(e[W-1 -: 2*N]));
    chk({tag, "_lock"},     32'(bus.o_lock),          32'(e[N*NBE+N -: N]));
    chk({tag, "_all_lock"}, 32'(bus.o_all_lock),      32'(e[N*NBE]));
    chk({tag, "_err"},      32'(bus.o_error_counter), 32'(e[N*NBE-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_lane(input int k);
    lane_data[k] = {$urandom, $urandom};
    lane_ctrl[k] = 8'($urandom_range(1, 255));
  endtask

  task automatic step(input bit en, input bit clr, input string tag);
    for (int k = 0; k < N; k++) begin
      bus.i_rx_raw_data[64*k +: 64] = lane_data[k];
      bus.i_rx_raw_ctrl[8*k +: 8]   = lane_ctrl[k];
    end
    bus.i_enable         = en;
    bus.i_clear_counters = clr;
    model_step(en, clr);
    exp_q.push_back(model_pack());
    @(posedge i_clock);
    #1;
    check_outputs(tag);
  endtask

  // Called one time unit after a rising edge; reset lands mid-cycle.
  task automatic async_reset(input string tag);
    #2;
    i_reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_pack());
    check_outputs(tag);
    chk({tag, "_zero"}, 32'(bus.o_lane_state), 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_reset  = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_clear_counters = 1'b0;
    bus.i_rx_raw_data = '0;
    bus.i_rx_raw_ctrl = '0;
    seeds = '{32'h00, 32'h40, 32'h80, 32'hC0};
    model_reset();
    #3;
    exp_q.push_back(model_pack());
    check_outputs("reset");
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;

    // Acquire on lane 0.
    for (int k = 1; k < N; k++) idle_lane(k);
    for (int i = 0; i < 4; i++) begin
      lane_data[0] = pat(8'(8'h10 + i));
      lane_ctrl[0] = 8'h00;
      step(1'b1, 1'b0, "acq");
      if (i == 0) chk("acq_first", 32'(bus.o_lane_state[1:0]), 32'd1);
      if (i == 2) chk("acq_third", 32'(bus.o_lock[0]), 32'd0);
    end
    chk("acq_locked", 32'(bus.o_lane_state[1:0]), 32'd2);
    chk("acq_lock0", 32'(bus.o_lock[0]), 32'd1);
    chk("acq_err0", 32'(bus.o_error_counter[3:0]), 32'd0);

    // Count through the 0xFF -> 0x00 wrap up to 0x1F.
    for (int v = 32'h14; v <= 32'h11F; v++) begin
      lane_data[0] = pat(8'(v));
      for (int k = 1; k < N; k++) idle_lane(k);
      step(1'b1, 1'b0, "wrap");
      if (v == 32'h101) begin
        chk("wrap_state", 32'(bus.o_lane_state[1:0]), 32'd2);
        chk("wrap_err", 32'(bus.o_error_counter[3:0]), 32'd0);
      end
    end

    // Disabled cycle with garbage is ignored.
    lane_data[0] = pat(8'hAA);
    step(1'b0, 1'b0, "disabled");
    chk("disabled_state", 32'(bus.o_lane_state[1:0]), 32'd2);

    // Ctrl block ignored, single slip, recovery, then loss.
    lane_data[0] = pat(8'h20); step(1'b1, 1'b0, "ctrl_pre");
    lane_data[0] = {$urandom, $urandom}; lane_ctrl[0] = 8'h80;
    step(1'b1, 1'b0, "ctrl_blk");
    chk("ctrl_hold", 32'(bus.o_lane_state[1:0]), 32'd2);
    lane_ctrl[0] = 8'h00;
    lane_data[0] = pat(8'h21); step(1'b1, 1'b0, "ctrl_post");
    lane_data[0] = pat(8'hAA); step(1'b1, 1'b0, "slip");
    chk("slip_state", 32'(bus.o_lane_state[1:0]), 32'd3);
    chk("slip_lock", 32'(bus.o_lock[0]), 32'd1);
    chk("slip_err", 32'(bus.o_error_counter[3:0]), 32'd1);
    lane_data[0] = pat(8'h23); step(1'b1, 1'b0, "relock");
    chk("relock_state", 32'(bus.o_lane_state[1:0]), 32'd2);
    for (int j = 0; j < 3; j++) begin
      lane_data[0] = {$urandom, $urandom};
      step(1'b1, 1'b0, "lose");
      if (j == 1) chk("lose_mid", 32'(bus.o_lane_state[1:0]), 32'd3);
    end
    chk("lose_state", 32'(bus.o_lane_state[1:0]), 32'd0);
    chk("lose_err", 32'(bus.o_error_counter[3:0]), 32'd4);

    // Saturation on lane 1, then clear colliding with an increment.
    idle_lane(0);
    for (int i = 0; i < 4; i++) begin
      lane_data[1] = pat(8'(8'h30 + i)); lane_ctrl[1] = 8'h00;
      step(1'b1, 1'b0, "sat_lock");
    end
    begin
      int e;
      e = 32'h34;
      for (int j = 0; j < 20; j++) begin
        lane_data[1] = pat(8'(e + $urandom_range(1, 255))); step(1'b1, 1'b0, "sat_bad");
        lane_data[1] = pat(8'(e + 1));                      step(1'b1, 1'b0, "sat_good");
        e += 2;
      end
      chk("sat_err", 32'(bus.o_error_counter[7:4]), 32'd15);
      lane_data[1] = pat(8'(e + 7));
      step(1'b1, 1'b1, "clr_collide");
      chk("clr_err", 32'(bus.o_error_counter[7:4]), 32'd0);
      chk("clr_state", 32'(bus.o_lane_state[3:2]), 32'd3);
    end

    // All four lanes locked on different seeds; then break lane 2 only.
    async_reset("rst_all");
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) begin
        lane_data[k] = pat(8'(seeds[k] + i)); lane_ctrl[k] = 8'h00;
      end
      step(1'b1, 1'b0, "all_lock");
    end
    chk("all_lock_on", 32'(bus.o_all_lock), 32'd1);
    chk("all_lock_states", 32'(bus.o_lane_state), 32'hAA);
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < N; k++) lane_data[k] = pat(8'(seeds[k] + 4 + j));
      lane_data[2] = pat(8'(seeds[2] + 4 + j + 8'h10));
      step(1'b1, 1'b0, "break2");
      if (j == 0) chk("break2_slip_all", 32'(bus.o_all_lock), 32'd1);
    end
    chk("break2_all", 32'(bus.o_all_lock), 32'd0);
    chk("break2_lock", 32'(bus.o_lock), 32'hB);
    chk("break2_states", 32'(bus.o_lane_state), 32'h8A);

    // Async reset mid-ACQ (lane 0) and mid-SLIP (lane 3).
    async_reset("rst_pre");
    for (int s = 0; s < 4; s++) begin
      idle_lane(1); idle_lane(2);
      lane_data[3] = pat(8'(8'h60 + s)); lane_ctrl[3] = 8'h00;
      if (s < 2) idle_lane(0);
      else begin lane_data[0] = pat(8'(8'h50 + s - 2)); lane_ctrl[0] = 8'h00; end
      step(1'b1, 1'b0, "mid_setup");
    end
    idle_lane(0);
    lane_data[3] = pat(8'h97);
    step(1'b1, 1'b0, "mid_slip");
    chk("mid_states", 32'(bus.o_lane_state), 32'hC1);
    async_reset("rst_mid");
    idle_lane(3);
    for (int s = 0; s < 4; s++) begin
      lane_data[0] = pat(8'(8'h52 + s)); lane_ctrl[0] = 8'h00;
      step(1'b1, 1'b0, "relock_fresh");
      if (s == 2) chk("fresh_not_yet", 32'(bus.o_lock[0]), 32'd0);
    end
    chk("fresh_locked", 32'(bus.o_lane_state[1:0]), 32'd2);

    // Random traffic against the model.
    for (int k = 0; k < N; k++) tx[k] = $urandom_range(0, 255);
    for (int c = 0; c < 400; c++) begin
      bit en, clr;
      for (int k = 0; k < N; k++) begin
        int r;
        r = $urandom_range(0, 99);
        lane_ctrl[k] = 8'h00;
        if (r < 75) begin
          lane_data[k] = pat(8'(tx[k])); tx[k]++;
        end else if (r < 85) begin
          lane_data[k] = pat(8'(tx[k] + $urandom_range(1, 255))); tx[k]++;
        end else if (r < 92) begin
          lane_data[k] = {$urandom, $urandom};
        end else begin
          idle_lane(k);
        end
      end
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(en, clr, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
